// File: rtl/acc_serial_receiver.sv
// Receive end of the accumulator readout link: rebuilds parallel words from the serialStart /
// serialIn stream and hands them out through a first-word fall-through FIFO.
module acc_serial_receiver #(
   parameter int unsigned ACC_WIDTH  = 16,
   parameter int unsigned NUM_WORDS  = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned IdxW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 serialStart,
   input  logic                 serialIn,
   input  logic                 clearFlags,
   output logic [ACC_WIDTH-1:0] wordData,
   output logic [IdxW-1:0]      wordIndex,
   output logic                 wordValid,
   input  logic                 wordReady,
   output logic                 frameDone,
   output logic [15:0]          frameCount,
   output logic                 overflow,
   output logic                 framingError
);

   localparam int unsigned BitW = $clog2(ACC_WIDTH);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [BitW-1:0] LastBit  = BitW'(ACC_WIDTH - 1);
   localparam logic [IdxW-1:0] LastWord = IdxW'(NUM_WORDS - 1);
   localparam logic [CntW-1:0] Depth    = CntW'(FIFO_DEPTH);

   typedef enum logic [0:0] {StIdle, StShift} state_e;
   typedef logic [IdxW+ACC_WIDTH-1:0] entry_t;

   state_e               state_q, state_d;
   logic [ACC_WIDTH-1:0] shift_q, assembled;
   logic [BitW-1:0]      bit_cnt_q;
   logic [IdxW-1:0]      word_cnt_q;
   logic                 last_bit, last_word;
   logic                 load, mid_err, push, frame_end;
   logic                 frame_done_q, overflow_q, framing_error_q;
   logic [15:0]          frame_count_q;

   entry_t               mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      count_q;
   logic                 empty, full, pop, do_push, ovf_set;

   assign assembled = {shift_q[ACC_WIDTH-2:0], serialIn};
   assign last_bit  = (bit_cnt_q == LastBit);
   assign last_word = (word_cnt_q == LastWord);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (serialStart) state_d = StShift;
         StShift: if (!serialStart && last_bit && last_word) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Any start seen while shifting is mid-frame: a legal back-to-back start always lands in idle.
   always_comb begin
      load      = serialStart;
      mid_err   = 1'b0;
      push      = 1'b0;
      frame_end = 1'b0;
      case (state_q)
         StShift: begin
            mid_err   = serialStart;
            push      = !serialStart && last_bit;
            frame_end = !serialStart && last_bit && last_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_q         <= '0;
         bit_cnt_q       <= '0;
         word_cnt_q      <= '0;
         frame_done_q    <= 1'b0;
         frame_count_q   <= '0;
         overflow_q      <= 1'b0;
         framing_error_q <= 1'b0;
      end else begin
         if (load) begin
            shift_q    <= ACC_WIDTH'(serialIn);
            bit_cnt_q  <= BitW'(1);
            word_cnt_q <= '0;
         end else if (state_q == StShift) begin
            shift_q <= assembled;
            if (push) begin
               bit_cnt_q  <= '0;
               word_cnt_q <= frame_end ? '0 : word_cnt_q + IdxW'(1);
            end else begin
               bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
         end
         frame_done_q    <= frame_end;
         frame_count_q   <= frame_count_q + 16'(frame_end);
         overflow_q      <= (overflow_q & ~clearFlags) | ovf_set;
         framing_error_q <= (framing_error_q & ~clearFlags) | mid_err;
      end
   end

   assign empty   = (count_q == '0);
   assign full    = (count_q == Depth);
   assign pop     = !empty && wordReady;
   assign do_push = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({do_push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {word_cnt_q, assembled};
   end

   assign wordValid               = !empty;
   assign {wordIndex, wordData}   = empty ? '0 : mem_q[rd_ptr_q];
   assign frameDone               = frame_done_q;
   assign frameCount              = frame_count_q;
   assign overflow                = overflow_q;
   assign framingError            = framing_error_q;

endmodule

// File: tb/tb_acc_serial_receiver.sv
// Bench for acc_serial_receiver: bit-level stimulus against a queue-based model of the link,
// checked every cycle.
module tb_acc_serial_receiver;

   localparam int W = 16;
   localparam int N = 4;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          serialStart = 1'b0;
   logic          serialIn = 1'b0;
   logic          clearFlags = 1'b0;
   logic          wordReady = 1'b0;
   logic [W-1:0]  wordData;
   logic [1:0]    wordIndex;
   logic          wordValid;
   logic          frameDone;
   logic [15:0]   frameCount;
   logic          overflow;
   logic          framingError;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [17:0] m_q[$];
   bit          m_in_frame;
   int          m_pos;
   logic [15:0] m_acc;
   logic [15:0] m_frames;
   bit          m_done, m_ovf, m_ferr;

   acc_serial_receiver #(
      .ACC_WIDTH  (W),
      .NUM_WORDS  (N),
      .FIFO_DEPTH (D)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .serialStart  (serialStart),
      .serialIn     (serialIn),
      .clearFlags   (clearFlags),
      .wordData     (wordData),
      .wordIndex    (wordIndex),
      .wordValid    (wordValid),
      .wordReady    (wordReady),
      .frameDone    (frameDone),
      .frameCount   (frameCount),
      .overflow     (overflow),
      .framingError (framingError)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_q.delete();
      m_in_frame = 0;
      m_pos      = 0;
      m_acc      = '0;
      m_frames   = '0;
      m_done     = 0;
      m_ovf      = 0;
      m_ferr     = 0;
   endfunction

   // Frame position counts bits received since the start marker; every W bits makes a word.
   function automatic void model_edge(input bit st, input bit b, input bit rdy, input bit clr);
      bit          pop, push, ovf_set, ferr_set;
      logic [17:0] item;
      pop      = (m_q.size() > 0) && rdy;
      push     = 0;
      ovf_set  = 0;
      ferr_set = 0;
      item     = '0;
      m_done   = 0;
      if (st) begin
         ferr_set   = m_in_frame;
         m_in_frame = 1;
         m_pos      = 1;
         m_acc      = {15'b0, b};
      end else if (m_in_frame) begin
         m_acc = {m_acc[14:0], b};
         m_pos++;
         if (m_pos % W == 0) begin
            push = 1;
            item = {2'(m_pos / W - 1), m_acc};
         end
         if (m_pos == N * W) begin
            m_done     = 1;
            m_frames   = m_frames + 16'd1;
            m_in_frame = 0;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < D) m_q.push_back(item);
         else ovf_set = 1;
      end
      m_ovf  = (m_ovf && !clr) || ovf_set;
      m_ferr = (m_ferr && !clr) || ferr_set;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [17:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 18'h0;
      check("wordValid", 32'(wordValid), 32'(m_q.size() > 0));
      check("wordData", 32'(wordData), 32'(head[15:0]));
      check("wordIndex", 32'(wordIndex), 32'(head[17:16]));
      check("frameDone", 32'(frameDone), 32'(m_done));
      check("frameCount", 32'(frameCount), 32'(m_frames));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("framingError", 32'(framingError), 32'(m_ferr));
   endtask

   task automatic step(input bit st, input bit b, input bit rdy, input bit clr);
      serialStart = st;
      serialIn    = b;
      wordReady   = rdy;
      clearFlags  = clr;
      @(posedge clk);
      model_edge(st, b, rdy, clr);
      #1;
      check_all();
   endtask

   // rdy_mode: 0 never ready, 1 always ready, 2 random, 3 ready only on each word's last bit
   task automatic send_frame(input logic [63:0] f, input int nbits, input int rdy_mode,
                             input bit clr_first);
      bit rdy;
      for (int i = 0; i < nbits; i++) begin
         case (rdy_mode)
            0:       rdy = 0;
            1:       rdy = 1;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (i % W == W - 1);
         endcase
         step(i == 0, f[63 - i], rdy, clr_first && (i == 0));
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 1'($urandom_range(0, 1)), rdy, 0);
   endtask

   function automatic logic [63:0] rand_frame();
      return {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
   endfunction

   initial begin
      logic [63:0] known;
      known = 64'h1234_ABCD_0001_FFFF;

      // Reset values
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      idle(3, 1);

      // Single frame
      send_frame(known, 64, 1, 0);
      idle(4, 1);
      check("single_frame_count", 32'(frameCount), 32'd1);

      // Back-to-back frames
      send_frame(rand_frame(), 64, 1, 0);
      send_frame(rand_frame(), 64, 1, 0);
      send_frame(known, 64, 1, 0);
      idle(4, 1);

      // Backpressure: overflow at the fifth push, then drain
      send_frame(known, 64, 0, 0);
      send_frame(rand_frame(), 64, 0, 0);
      check("bp_overflow", 32'(overflow), 32'd1);
      idle(8, 1);
      step(0, 0, 1, 1);
      // Full FIFO with push and pop together must not overflow
      send_frame(rand_frame(), 64, 0, 0);
      send_frame(rand_frame(), 64, 3, 0);
      check("full_push_pop_no_ovf", 32'(overflow), 32'd0);
      idle(8, 1);

      // Mid-frame start during bit 7 of word 1
      send_frame(known, 23, 1, 0);
      send_frame(rand_frame(), 64, 1, 0);
      check("midframe_ferr", 32'(framingError), 32'd1);
      idle(4, 1);
      // New error in the same cycle as clearFlags keeps the flag
      send_frame(rand_frame(), 10, 1, 0);
      send_frame(known, 64, 1, 1);
      check("clear_vs_set", 32'(framingError), 32'd1);
      step(0, 0, 1, 1);
      idle(3, 1);

      // Reset during word 2
      send_frame(rand_frame(), 40, 2, 0);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle(5, 1);
      send_frame(known, 64, 1, 0);
      idle(4, 1);
      check("post_reset_count", 32'(frameCount), 32'd1);

      // Random traffic: random ready, gaps, and flag clears
      for (int k = 0; k < 12; k++) begin
         send_frame(rand_frame(), ($urandom_range(0, 7) == 0) ? 30 : 64, 2, 0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) step(0, 0, 1, 1);
      end
      idle(10, 1);

      // frameCount wrap
      force dut.frame_count_q = 16'hFFFF;
      #1;
      release dut.frame_count_q;
      m_frames = 16'hFFFF;
      check("preload_count", 32'(frameCount), 32'hFFFF);
      send_frame(rand_frame(), 64, 1, 0);
      check("wrap_count", 32'(frameCount), 32'h0);
      idle(6, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
